// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared definitions for the instruction fetch controller: FSM state
//   encoding, the NOP used to fill an empty decode slot, and the default
//   datapath width.
package fetch_ctrl_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  // FETCH: normal operation.
  // DROP : a request is outstanding whose returning data is stale and is
  //        discarded when it arrives.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_buf.sv
// fetch_ctrl_buf
//   Two-entry shift FIFO holding {pc, instr} pairs between instruction
//   memory and decode. Entry e0 is always the head, so the head output is a
//   plain register that holds its value while decode stalls.
// Ports
//   clk, rst   clock, synchronous active-high reset
//   push, din  write one entry (ignored when full and not popping)
//   pop        remove the head (ignored when empty)
//   flush      empty the FIFO; overrides push and pop
//   count      current occupancy, 0..2
//   head       head entry (meaningful only when count != 0)
module fetch_ctrl_buf #(
  parameter int             W       = 64,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = e0;

  always_ff @(posedge clk) begin
    if (rst) begin
      e0    <= RST_VAL;
      e1    <= RST_VAL;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
      case (count)
        2'd0: if (do_push) e0 <= din;
        2'd1: begin
          if (do_push && do_pop) e0 <= din;
          else if (do_push)      e1 <= din;
        end
        default: begin
          if (do_pop) e0 <= e1;
          if (do_push) e1 <= din;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction fetch sequencer. Owns the PC, issues word requests to
//   instruction memory, buffers returned words in a 2-entry FIFO and
//   presents {pc, instr} to decode. Execute-stage redirects flush the buffer
//   and any in-flight request is dropped when its data returns.
//
// Handshakes: imem_req/imem_ack -- imem_req is registered and, once high,
//   stays high with imem_addr stable until the cycle imem_ack is sampled
//   high; imem_ack is ignored while imem_req is low. if_valid/if_ready --
//   an entry transfers on any cycle with if_valid & if_ready; while
//   if_ready is low the presented entry is held unchanged.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   fetch_en                 allow new requests
//   imem_req/addr/ack/rdata  instruction memory port
//   redirect_valid/pc        one-cycle redirect from execute
//   if_valid/ready/pc/instr  decode port
//   misalign_err             one-cycle pulse for a misaligned redirect target
//   state                    current FSM state, for observation
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            misalign_err,
  output fetch_state_e    state
);

  logic [XLEN-1:0]   pc;
  logic [1:0]        occ;
  logic [1:0]        occ_next;
  logic [2*XLEN-1:0] head;
  logic              acked;
  logic              push;
  logic              pop;
  logic              may_issue;

  assign acked = imem_req && imem_ack;
  // A redirect flushes the buffer, so it suppresses this cycle's push/pop.
  assign push  = !redirect_valid && (state == ST_FETCH) && acked;
  assign pop   = !redirect_valid && if_valid && if_ready;

  // Issuing only when the post-edge occupancy is at most 1 leaves room for
  // the response of the new request, so an ack never finds the buffer full.
  assign occ_next  = occ + {1'b0, push} - {1'b0, pop};
  assign may_issue = fetch_en && (!imem_req || imem_ack) && (occ_next <= 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      state        <= ST_FETCH;
      imem_req     <= 1'b0;
      imem_addr    <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
        if (imem_req && !imem_ack) begin
          // Keep the request up until memory answers, then discard it.
          state <= ST_DROP;
        end else begin
          // Any data arriving now is stale; the target issues next cycle.
          state    <= ST_FETCH;
          imem_req <= 1'b0;
        end
      end else if (may_issue) begin
        // Also covers DROP completing: the stale ack ends it and the next
        // request goes out on the same edge.
        state     <= ST_FETCH;
        imem_req  <= 1'b1;
        imem_addr <= pc;
        pc        <= pc + XLEN'(4);
      end else if (acked) begin
        state    <= ST_FETCH;
        imem_req <= 1'b0;
      end
    end
  end

  fetch_ctrl_buf #(
    .W       (2 * XLEN),
    .RST_VAL ({{XLEN{1'b0}}, XLEN'(NOP_INSTR)})
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({imem_addr, imem_rdata}),
    .count (occ),
    .head  (head)
  );

  assign if_valid = (occ != 2'd0);
  assign if_pc    = head[2*XLEN-1:XLEN];
  assign if_instr = head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         fetch_en = 1'b1;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         if_valid;
  logic         if_ready = 1'b1;
  logic [31:0]  if_pc;
  logic [31:0]  if_instr;
  logic         misalign_err;
  fetch_state_e state;

  // memory model: returns its own address; zero-wait or manually acked
  logic ack_zero   = 1'b1;
  logic ack_manual = 1'b0;
  assign imem_ack   = ack_zero ? imem_req : ack_manual;
  assign imem_rdata = imem_addr;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err),
    .state          (state)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_pc"}, if_pc, 32'd0);
    chk({tag, "_instr"}, if_instr, 32'h0000_0013);
    chk({tag, "_mis"}, 32'(misalign_err), 32'd0);
    chk({tag, "_state"}, 32'(state), 32'(ST_FETCH));
  endtask

  initial begin
    // 1: reset and zero-wait streaming
    tick(); tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid_e1", 32'(if_valid), 32'd0);
    tick();
    chk("t1_valid_e2", 32'(if_valid), 32'd1);
    chk("t1_pc0", if_pc, 32'h0);
    chk("t1_instr0", if_instr, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_pc", if_pc, 32'(4 * i));
      chk("t1_instr", if_instr, 32'(4 * i));
    end

    // 2: decode stall for 5 cycles
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_req_low", 32'(imem_req), 32'd0);
      chk("t2_hold_pc", if_pc, 32'hC);
      chk("t2_hold_valid", 32'(if_valid), 32'd1);
    end
    if_ready = 1'b1;
    tick();
    chk("t2_reissue", imem_addr, 32'h14);
    chk("t2_pc16", if_pc, 32'h10);
    tick();
    chk("t2_pc20", if_pc, 32'h14);
    tick();
    chk("t2_pc24", if_pc, 32'h18);
    chk("t2_valid", 32'(if_valid), 32'd1);

    // 3: slow memory, redirect during a request to 0x10
    rst = 1'b1; fetch_en = 1'b0; ack_zero = 1'b0; ack_manual = 1'b0;
    tick();
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    chk("t3_idle_req", 32'(imem_req), 32'd0);
    redirect_valid = 1'b0; fetch_en = 1'b1;
    tick();
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr10", imem_addr, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t3_hold_a", imem_addr, 32'h10);
    chk("t3_drop", 32'(state), 32'(ST_DROP));
    tick();
    chk("t3_hold_b", imem_addr, 32'h10);
    chk("t3_hold_req", 32'(imem_req), 32'd1);
    chk("t3_novalid", 32'(if_valid), 32'd0);
    ack_manual = 1'b1;
    tick();
    chk("t3_addr40", imem_addr, 32'h40);
    chk("t3_req40", 32'(imem_req), 32'd1);
    chk("t3_stale_dropped", 32'(if_valid), 32'd0);
    chk("t3_back_fetch", 32'(state), 32'(ST_FETCH));
    ack_manual = 1'b0; ack_zero = 1'b1;
    tick();
    chk("t3_first_valid", 32'(if_valid), 32'd1);
    chk("t3_first_pc", if_pc, 32'h40);
    chk("t3_first_instr", if_instr, 32'h40);

    // 4: redirect + ack + ready in the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("t4_valid0", 32'(if_valid), 32'd0);
    chk("t4_req0", 32'(imem_req), 32'd0);
    tick();
    chk("t4_addr", imem_addr, 32'h80);
    chk("t4_valid_still0", 32'(if_valid), 32'd0);
    tick();
    chk("t4_pc", if_pc, 32'h80);
    chk("t4_instr", if_instr, 32'h80);

    // 5: misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect_valid = 1'b0;
    chk("t5_mis1", 32'(misalign_err), 32'd1);
    chk("t5_valid0", 32'(if_valid), 32'd0);
    tick();
    chk("t5_mis_pulse", 32'(misalign_err), 32'd0);
    chk("t5_addr", imem_addr, 32'h40);
    tick();
    chk("t5_pc", if_pc, 32'h40);

    // 6: reset while a request is outstanding, late ack ignored
    ack_zero = 1'b0; ack_manual = 1'b0;
    tick();
    chk("t6_outstanding", 32'(imem_req), 32'd1);
    chk("t6_out_addr", imem_addr, 32'h44);
    rst = 1'b1;
    tick();
    chk_reset("t6_rst");
    ack_manual = 1'b1;
    tick();
    chk_reset("t6_ack_ign");
    rst = 1'b0; ack_manual = 1'b0;
    tick();
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", imem_addr, 32'h0);

    // PC wrap at the top of the address space
    ack_zero = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_req0", 32'(imem_req), 32'd0);
    tick();
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr0", imem_addr, 32'h0);
    chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc0", if_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
